// File: rtl/uart_rx_fifo.sv
// Generic circular FIFO: zero-latency head (first-word fall-through); a push
// into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 4
) (
    input  logic             testClock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LOG2:0]    count,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 1 << LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2-1:0]  wrptr;
    logic [LOG2-1:0]  rdptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == (LOG2+1)'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rdptr];

    always_ff @(posedge testClock) begin
        if (Reset) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
        end else begin
            if (wr_en)
                wrptr <= wrptr + 1'b1;
            if (rd_en)
                rdptr <= rdptr + 1'b1;
            count <= count + (LOG2+1)'(wr_en) - (LOG2+1)'(rd_en);
        end
    end

    always_ff @(posedge testClock) begin
        if (wr_en)
            mem[wrptr] <= din;
    end
endmodule

// uart_rx_fifo: 8N1 receiver into a FIFO polled by the CPU; UART_RX_PARITY_EN selects 8E1 + parityErr.
// Byte visible 9.5*BIT_CYCLES+3 cycles after the start edge; a full FIFO drops the byte and sets overrun.
module uart_rx_fifo #(
    parameter int BIT_CYCLES = 347,
    parameter int FIFO_LOG2  = 4
) (
    input  logic                 testClock,
    input  logic                 Reset,
    input  logic                 RxD,
    input  logic                 readRX,
    output logic                 charReady,
    output logic [7:0]           RXchar,
    output logic                 overrun,
    output logic                 frameErr,
`ifdef UART_RX_PARITY_EN
    output logic                 parityErr,
`endif
    output logic [FIFO_LOG2:0]   rxCount
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(BIT_CYCLES / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitidx;
    logic [7:0]      shift;
    logic            push;
    logic            cnt_zero;
    logic [7:0]      fifo_dout;
    logic            fifo_empty;
    logic            fifo_full;
    logic [7:0]      hold;
`ifdef UART_RX_PARITY_EN
    logic            perr;
`endif

    always_ff @(posedge testClock) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    assign cnt_zero = (cnt == '0);

    // The stop sample itself pushes, so a following start edge is never missed.
`ifdef UART_RX_PARITY_EN
    assign push = (state == STOP) && cnt_zero && rxs && !perr;
`else
    assign push = (state == STOP) && cnt_zero && rxs;
`endif

    always_ff @(posedge testClock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bitidx   <= '0;
            shift    <= '0;
            frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr      <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            case (state)
                // IDLE is only entered with rxs high, so a low rxs here is the start edge.
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF_RELOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        cnt    <= BIT_RELOAD;
                        bitidx <= '0;
`ifdef UART_RX_PARITY_EN
                        perr   <= 1'b0;
`endif
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift[bitidx] <= rxs;
                        cnt           <= BIT_RELOAD;
                        if (bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitidx <= bitidx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        perr <= (^shift) ^ rxs;
                        if ((^shift) ^ rxs)
                            parityErr <= 1'b1;
                        cnt   <= BIT_RELOAD;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        frameErr <= 1'b1;
                        state    <= BREAK;
                    end
                end
                BREAK: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo #(
        .WIDTH (8),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .testClock (testClock),
        .Reset     (Reset),
        .push      (push),
        .din       (shift),
        .pop       (readRX),
        .dout      (fifo_dout),
        .count     (rxCount),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // A same-cycle pop on a full FIFO makes room, so only an unmatched push overruns.
    always_ff @(posedge testClock) begin
        if (Reset)
            overrun <= 1'b0;
        else if (push && fifo_full && !readRX)
            overrun <= 1'b1;
    end

    always_ff @(posedge testClock) begin
        if (Reset)
            hold <= '0;
        else if (charReady)
            hold <= fifo_dout;
    end

    assign charReady = !fifo_empty;
    assign RXchar    = charReady ? fifo_dout : hold;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int BC   = 16;
    localparam int LOG2 = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_LAT = 171;
`else
    localparam int PUSH_LAT = 155;
`endif

    logic       testClock = 1'b0;
    logic       Reset     = 1'b1;
    logic       RxD       = 1'b1;
    logic       readRX    = 1'b0;
    logic       charReady;
    logic [7:0] RXchar;
    logic       overrun;
    logic       frameErr;
    logic [2:0] rxCount;
`ifdef UART_RX_PARITY_EN
    logic       parityErr;
    logic       par_flip = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 testClock = ~testClock;

    uart_rx_fifo #(.BIT_CYCLES(BC), .FIFO_LOG2(LOG2)) dut (
        .testClock (testClock),
        .Reset     (Reset),
        .RxD       (RxD),
        .readRX    (readRX),
        .charReady (charReady),
        .RXchar    (RXchar),
        .overrun   (overrun),
        .frameErr  (frameErr),
`ifdef UART_RX_PARITY_EN
        .parityErr (parityErr),
`endif
        .rxCount   (rxCount)
    );

    // All stimulus tasks start and end on a falling clock edge.
    task automatic send_frame(input logic [7:0] d, input int stop_low);
        RxD = 1'b0;
        repeat (BC) @(negedge testClock);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            repeat (BC) @(negedge testClock);
        end
`ifdef UART_RX_PARITY_EN
        RxD = (^d) ^ par_flip;
        repeat (BC) @(negedge testClock);
`endif
        if (stop_low > 0) begin
            RxD = 1'b0;
            repeat (BC * stop_low) @(negedge testClock);
        end
        RxD = 1'b1;
        repeat (BC) @(negedge testClock);
    endtask

    task automatic pop_one;
        readRX = 1'b1;
        @(negedge testClock);
        readRX = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge testClock);
        Reset  = 1'b1;
        RxD    = 1'b1;
        readRX = 1'b0;
        repeat (3) @(negedge testClock);
        Reset = 1'b0;
        repeat (2) @(negedge testClock);
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (charReady !== 1'b0) begin bad++; $display("FAIL reset_charReady: got %b want 0", charReady); end
        total++; if (RXchar !== 8'h00) begin bad++; $display("FAIL reset_RXchar: got %h want 00", RXchar); end
        total++; if (rxCount !== 3'd0) begin bad++; $display("FAIL reset_rxCount: got %0d want 0", rxCount); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (frameErr !== 1'b0) begin bad++; $display("FAIL reset_frameErr: got %b want 0", frameErr); end
`ifdef UART_RX_PARITY_EN
        total++; if (parityErr !== 1'b0) begin bad++; $display("FAIL reset_parityErr: got %b want 0", parityErr); end
`endif
    endtask

    task automatic test_single;
        int cyc;
        cyc = 0;
        fork
            send_frame(8'hA5, 0);
            begin
                @(posedge testClock);
                #1;
                while (!charReady && cyc < 400) begin
                    @(posedge testClock);
                    #1;
                    cyc++;
                end
            end
        join
        @(negedge testClock);
        total++; if (cyc < PUSH_LAT - 1 || cyc > PUSH_LAT + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d+-1", cyc, PUSH_LAT); end
        total++; if (RXchar !== 8'hA5) begin bad++; $display("FAIL single_RXchar: got %h want a5", RXchar); end
        total++; if (rxCount !== 3'd1) begin bad++; $display("FAIL single_rxCount: got %0d want 1", rxCount); end
        pop_one();
        total++; if (charReady !== 1'b0) begin bad++; $display("FAIL single_pop_charReady: got %b want 0", charReady); end
        total++; if (rxCount !== 3'd0) begin bad++; $display("FAIL single_pop_rxCount: got %0d want 0", rxCount); end
        total++; if (RXchar !== 8'hA5) begin bad++; $display("FAIL single_hold_RXchar: got %h want a5", RXchar); end
        pop_one();
        total++; if (rxCount !== 3'd0) begin bad++; $display("FAIL empty_pop_rxCount: got %0d want 0", rxCount); end
    endtask

    task automatic test_glitch;
        RxD = 1'b0;
        repeat (4) @(negedge testClock);
        RxD = 1'b1;
        repeat (40) @(negedge testClock);
        total++; if (charReady !== 1'b0) begin bad++; $display("FAIL glitch_charReady: got %b want 0", charReady); end
        total++; if (frameErr !== 1'b0) begin bad++; $display("FAIL glitch_frameErr: got %b want 0", frameErr); end
        total++; if (rxCount !== 3'd0) begin bad++; $display("FAIL glitch_rxCount: got %0d want 0", rxCount); end
        send_frame(8'hC3, 0);
        total++; if (RXchar !== 8'hC3) begin bad++; $display("FAIL glitch_next_RXchar: got %h want c3", RXchar); end
        pop_one();
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 0);
        total++; if (rxCount !== 3'd4) begin bad++; $display("FAIL b2b_rxCount: got %0d want 4", rxCount); end
        total++; if (RXchar !== 8'h01) begin bad++; $display("FAIL b2b_RXchar: got %h want 01", RXchar); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
        for (int i = 0; i < 4; i++) begin
            total++; if (RXchar !== exp_b[i]) begin bad++; $display("FAIL b2b_pop%0d: got %h want %h", i, RXchar, exp_b[i]); end
            pop_one();
        end
        total++; if (charReady !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", charReady); end
    endtask

    task automatic test_frame_err;
        send_frame(8'h3C, 2);
        total++; if (frameErr !== 1'b1) begin bad++; $display("FAIL ferr_flag: got %b want 1", frameErr); end
        total++; if (rxCount !== 3'd0) begin bad++; $display("FAIL ferr_rxCount: got %0d want 0", rxCount); end
        repeat (10) @(negedge testClock);
        send_frame(8'h7E, 0);
        total++; if (RXchar !== 8'h7E) begin bad++; $display("FAIL ferr_next_RXchar: got %h want 7e", RXchar); end
        total++; if (rxCount !== 3'd1) begin bad++; $display("FAIL ferr_next_rxCount: got %0d want 1", rxCount); end
        total++; if (frameErr !== 1'b1) begin bad++; $display("FAIL ferr_sticky: got %b want 1", frameErr); end
        pop_one();
    endtask

    task automatic test_reset_midframe;
        send_frame(8'h99, 0);
        RxD = 1'b0;
        repeat (60) @(negedge testClock);
        Reset = 1'b1;
        repeat (2) @(negedge testClock);
        Reset = 1'b0;
        RxD   = 1'b1;
        @(negedge testClock);
        total++; if (charReady !== 1'b0) begin bad++; $display("FAIL midrst_charReady: got %b want 0", charReady); end
        total++; if (RXchar !== 8'h00) begin bad++; $display("FAIL midrst_RXchar: got %h want 00", RXchar); end
        total++; if (rxCount !== 3'd0) begin bad++; $display("FAIL midrst_rxCount: got %0d want 0", rxCount); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
        total++; if (frameErr !== 1'b0) begin bad++; $display("FAIL midrst_frameErr: got %b want 0", frameErr); end
        repeat (5) @(negedge testClock);
        send_frame(8'h5A, 0);
        total++; if (RXchar !== 8'h5A) begin bad++; $display("FAIL midrst_next_RXchar: got %h want 5a", RXchar); end
        total++; if (rxCount !== 3'd1) begin bad++; $display("FAIL midrst_next_rxCount: got %0d want 1", rxCount); end
        pop_one();
    endtask

    task automatic test_simul_push_pop;
        logic [7:0] exp_s [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        send_frame(8'h33, 0);
        send_frame(8'h44, 0);
        fork
            send_frame(8'h55, 0);
            begin
                repeat (PUSH_LAT) @(negedge testClock);
                total++; if (rxCount !== 3'd4) begin bad++; $display("FAIL simul_pre_rxCount: got %0d want 4", rxCount); end
                total++; if (RXchar !== 8'h11) begin bad++; $display("FAIL simul_pre_RXchar: got %h want 11", RXchar); end
                readRX = 1'b1;
                @(negedge testClock);
                readRX = 1'b0;
            end
        join
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL simul_overrun: got %b want 0", overrun); end
        total++; if (rxCount !== 3'd4) begin bad++; $display("FAIL simul_rxCount: got %0d want 4", rxCount); end
        for (int i = 0; i < 4; i++) begin
            total++; if (RXchar !== exp_s[i]) begin bad++; $display("FAIL simul_pop%0d: got %h want %h", i, RXchar, exp_s[i]); end
            pop_one();
        end
        total++; if (charReady !== 1'b0) begin bad++; $display("FAIL simul_empty: got %b want 0", charReady); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        par_flip = 1'b1;
        send_frame(8'h03, 0);
        par_flip = 1'b0;
        total++; if (parityErr !== 1'b1) begin bad++; $display("FAIL parity_flag: got %b want 1", parityErr); end
        total++; if (charReady !== 1'b0) begin bad++; $display("FAIL parity_drop: got %b want 0", charReady); end
        send_frame(8'h03, 0);
        total++; if (RXchar !== 8'h03) begin bad++; $display("FAIL parity_good_RXchar: got %h want 03", RXchar); end
        total++; if (rxCount !== 3'd1) begin bad++; $display("FAIL parity_good_rxCount: got %0d want 1", rxCount); end
        pop_one();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_back_to_back();
        test_frame_err();
        test_reset_midframe();
        test_simul_push_pop();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive end of the user RS232 link: deserialises 8N1 frames on RxD and buffers bytes in a small FIFO.
- Presents the charReady / RXchar / readRX interface that the CPU polls through IO device 0 (Ski/Skni skip, then IO read).
- Clocked from the same 40 MHz DCM output as the CPU.
- Adds sticky overrun and framing-error status.

Parameters:
- BIT_CYCLES, 347: clock cycles per bit (40 MHz / 115200 baud). Legal range 8..4095.
- FIFO_LOG2, 4: log2 of FIFO depth (default depth 16).

Ports:
- testClock  in  1  clock, 40 MHz
- Reset  in  1  synchronous, active-high
- RxD  in  1  asynchronous serial input, idle high
- readRX  in  1  pop strobe, one cycle per byte consumed
- charReady  out  1  FIFO not empty
- RXchar  out  8  FIFO head byte (first-word fall-through)
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- frameErr  out  1  sticky: a stop bit was sampled low
- rxCount  out  FIFO_LOG2+1  bytes held in the FIFO

Behaviour:
- Reset is synchronous and active-high; clock is testClock.
- Reset values: charReady=0, RXchar=0, overrun=0, frameErr=0, rxCount=0, FSM=IDLE, synchroniser=2'b11.
- Reset mid-frame aborts the frame and empties the FIFO.
- RxD passes through a 2-flop synchroniser (rxs) before any use.
- Bit counter and sample counter are ceil(log2(BIT_CYCLES)) bits wide.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: a falling edge on rxs loads counter=BIT_CYCLES/2 (integer divide) and goes to START.
  - START: when the counter reaches 0, sample rxs. If 1 (glitch), go to IDLE. If 0, load BIT_CYCLES, set bit index 0, go to DATA.
  - DATA: at each counter expiry, sample rxs into shift[bitidx], LSB first, and reload BIT_CYCLES. After bit 7, go to STOP.
  - STOP: at counter expiry, sample rxs.
    - If 1: push the byte, go to IDLE. No wait for a full stop bit, so back-to-back frames are received.
    - If 0: set frameErr, discard the byte, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE.
- Nominal latency: the byte is pushed 9.5*BIT_CYCLES + 3 cycles (±1) after the RxD falling edge.
- FIFO:
  - Circular buffer of 2^FIFO_LOG2 entries with FIFO_LOG2-bit read/write pointers that wrap modulo the depth.
  - rxCount ranges 0..2^FIFO_LOG2.
  - RXchar always equals mem[rdptr] when charReady=1. It is held at the last value when empty (0 after reset).
- Pop: readRX=1 with charReady=1 advances rdptr at the clock edge. readRX with an empty FIFO is ignored, with no underflow.
- Push into a full FIFO: the byte is dropped and overrun is set. FIFO contents are unchanged.
- Simultaneous push and pop:
  - Both take effect and rxCount is unchanged.
  - If the FIFO is full, the pop frees the slot and the push is accepted, with no overrun.
  - If the FIFO is empty, the pop is ignored and the push is accepted.
- Sticky flags clear only on Reset.
- charReady and RXchar are combinational from registers, with no decode from RxD. Both are stable for the full cycle in which the CPU samples them.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state between DATA and STOP samples one extra bit at BIT_CYCLES.
  - Even-parity mismatch sets a sticky output parityErr. The byte is discarded; the stop bit is still checked.
  - Push latency becomes 10.5*BIT_CYCLES + 3 cycles.
  - parityErr resets to 0.
- Undefined:
  - No PARITY state and no parityErr port. Frame is 8N1.

Test Plan (bench uses BIT_CYCLES=16, FIFO_LOG2=2):
- Single frame 0xA5, 8N1 at 16 cycles/bit -> charReady rises 155±1 cycles after the start edge, RXchar=0xA5, rxCount=1. Pulse readRX -> charReady=0, rxCount=0.
- Start glitch: RxD low for 4 cycles then high -> FSM returns to IDLE, no push, charReady stays 0, frameErr=0.
- Five back-to-back frames 0x01..0x05 with no reads -> rxCount=4, RXchar=0x01, overrun=1. Four pops return 0x01,0x02,0x03,0x04, then charReady=0.
- Frame 0x3C with the stop bit held low for 2 bit times -> frameErr=1, no push. The next valid frame 0x7E after the line returns high is received correctly.
- FIFO full, readRX asserted in the same cycle the 5th byte 0x55 is pushed -> overrun=0, rxCount=4, and the last pop yields 0x55. Assert Reset mid-frame -> all outputs return to reset values and the next frame is received normally.
- With UART_RX_PARITY_EN defined: 0x03 sent with parity bit 1 -> parityErr=1, no push. 0x03 sent with parity bit 0 -> RXchar=0x03.
